// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficient table and FSM encoding for the CIC droop compensation FIR.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cic_comp_pkg;

    localparam int CC_NTAPS = 21;
    localparam int CC_CSZ   = 18;
    localparam int CC_HALF  = (CC_NTAPS + 1) / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // First half of the symmetric set; last entry is the centre tap. Full-set sum is 2^17.
    localparam logic signed [CC_CSZ-1:0] CC_COEF [CC_HALF] = '{
        -18'sd120,  18'sd250,   -18'sd380,  18'sd520,   -18'sd900,
        18'sd1500,  -18'sd2600, 18'sd4800,  -18'sd9500, 18'sd30000,
        18'sd83932
    };

    // Buffer slot holding x[n-lag], where x[n] sits just behind the write pointer.
    function automatic int tap_idx(input int wptr, input int lag, input int ntaps);
        int i;
        i = wptr + ntaps - 1 - lag;
        if (i >= ntaps) begin
            i = i - ntaps;
        end
        return i;
    endfunction

endpackage

// File: rtl/cic_comp_coef_rom.sv
// Coefficient ROM for the compensation FIR, indexed by the MAC step.
// Latency: 1 cycle (registered read); addresses past the table return 0.
// Backpressure: none.
module cic_comp_coef_rom
    import cic_comp_pkg::*;
#(
    parameter int AW = $clog2(CC_HALF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AW-1:0]            addr,
    output logic signed [CC_CSZ-1:0] coef
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef <= '0;
        end else if (int'(addr) < CC_HALF) begin
            coef <= CC_COEF[addr];
        end else begin
            coef <= '0;
        end
    end

endmodule

// File: rtl/cic_comp_decimator.sv
// Decimate-by-2 symmetric FIR compensating CIC droop; CIC_COMP_SAT_EN clamps instead of wrapping.
// Latency: out_valid 13 cycles after the start sample (every 2nd accepted sample).
// Backpressure: none; samples arriving while busy are dropped and flag the sticky overrun.
module cic_comp_decimator
    import cic_comp_pkg::*;
#(
    parameter int ISZ   = 31,
    parameter int OSZ   = 16,
    parameter int CSZ   = CC_CSZ,
    parameter int NTAPS = CC_NTAPS,
    parameter int SHIFT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [ISZ-1:0] in,
    input  logic                  in_valid,
    output logic signed [OSZ-1:0] out,
    output logic                  out_valid,
    output logic                  overrun
);

    localparam int HALF = (NTAPS + 1) / 2;
    localparam int CW   = $clog2(HALF);
    localparam int PTRW = $clog2(NTAPS);
    localparam int PW   = ISZ + 1;
    localparam int MW   = PW + CSZ;
    localparam int AW   = ISZ + 1 + CSZ + CW;

    localparam logic signed [AW-1:0] RND  = (AW'(1) << SHIFT) >> 1;
    localparam logic signed [AW-1:0] OMAX = (AW'(1) << (OSZ - 1)) - AW'(1);
    localparam logic signed [AW-1:0] OMIN = ~OMAX;

    logic signed [ISZ-1:0] sbuf [NTAPS];
    logic [PTRW-1:0]       wptr;
    logic                  phase;
    state_e                state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         rom_addr;
    logic signed [CSZ-1:0] coef;
    logic signed [AW-1:0]  acc;

    logic                  accept;
    logic                  start;
    int                    ia;
    int                    ib;
    logic signed [ISZ-1:0] xa;
    logic signed [ISZ-1:0] xb;
    logic signed [PW-1:0]  pre;
    logic signed [MW-1:0]  prod;
    logic signed [OSZ-1:0] out_nxt;

    assign accept = in_valid && (state == ST_IDLE);
    assign start  = accept && phase;

    // ROM runs one step ahead so c[k] is registered by the time step k executes.
    assign rom_addr = (state == ST_MAC) ? cnt + CW'(1) : '0;

    cic_comp_coef_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  (rom_addr),
        .coef  (coef)
    );

    always_comb begin
        ia  = tap_idx(int'(wptr), int'(cnt), NTAPS);
        ib  = tap_idx(int'(wptr), NTAPS - 1 - int'(cnt), NTAPS);
        xa  = sbuf[PTRW'(ia)];
        xb  = (cnt == CW'(HALF - 1)) ? '0 : sbuf[PTRW'(ib)];
        pre = {xa[ISZ-1], xa} + {xb[ISZ-1], xb};
    end

    assign prod = $signed({{CSZ{pre[PW-1]}}, pre}) * $signed({{PW{coef[CSZ-1]}}, coef});

    always_comb begin
`ifdef CIC_COMP_SAT_EN
        if (acc > OMAX) begin
            out_nxt = OMAX[OSZ-1:0];
        end else if (acc < OMIN) begin
            out_nxt = OMIN[OSZ-1:0];
        end else begin
            out_nxt = acc[OSZ-1:0];
        end
`else
        out_nxt = acc[OSZ-1:0];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                sbuf[i] <= '0;
            end
            wptr    <= '0;
            phase   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                sbuf[wptr] <= in;
                wptr       <= (wptr == PTRW'(NTAPS - 1)) ? '0 : wptr + PTRW'(1);
                phase      <= ~phase;
            end
            if (in_valid && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_MAC;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                ST_MAC: begin
                    acc <= acc + {{(AW - MW){prod[MW-1]}}, prod};
                    if (cnt == CW'(HALF - 1)) begin
                        cnt   <= '0;
                        state <= ST_ROUND;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_ROUND: begin
                    acc   <= (acc + RND) >>> SHIFT;
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    out       <= out_nxt;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cic_comp_decimator.sv
// Bench for cic_comp_decimator: direct-convolution reference model plus literal expectations.
module tb_cic_comp_decimator;

    localparam int NT = 21;
    localparam longint H [NT] = '{
        -120, 250, -380, 520, -900, 1500, -2600, 4800, -9500, 30000, 83932,
        30000, -9500, 4800, -2600, 1500, -900, 520, -380, 250, -120
    };

    typedef struct {
        int     cyc;
        longint val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic signed [30:0] in_m = '0;
    logic               vld_m = 1'b0;
    logic signed [15:0] out_m;
    logic               ov_m;
    logic               ovr_m;

    logic signed [30:0] in_i = '0;
    logic               vld_i = 1'b0;
    logic signed [47:0] out_i;
    logic               ov_i;
    logic               ovr_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cic_comp_decimator u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .in        (in_m),
        .in_valid  (vld_m),
        .out       (out_m),
        .out_valid (ov_m),
        .overrun   (ovr_m)
    );

    cic_comp_decimator #(.OSZ(48), .SHIFT(0)) u_imp (
        .clk       (clk),
        .reset     (rst_n),
        .in        (in_i),
        .in_valid  (vld_i),
        .out       (out_i),
        .out_valid (ov_i),
        .overrun   (ovr_i)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // y[n] = sum_j h[j] x[n-j], x before reset = 0, then round/shift and clamp or wrap
    function automatic longint model_y(input longint xs[$], input int sh, input int osz);
        longint y;
        int     n;
        y = 0;
        n = xs.size() - 1;
        for (int j = 0; j < NT; j++) begin
            if (n - j >= 0) y += H[j] * xs[n - j];
        end
        if (sh > 0) y = (y + (longint'(1) <<< (sh - 1))) >>> sh;
`ifdef CIC_COMP_SAT_EN
        if (y > (longint'(1) <<< (osz - 1)) - 1) y = (longint'(1) <<< (osz - 1)) - 1;
        if (y < -(longint'(1) <<< (osz - 1))) y = -(longint'(1) <<< (osz - 1));
`else
        y = (y <<< (64 - osz)) >>> (64 - osz);
`endif
        return y;
    endfunction

    longint hist_m[$];
    exp_t   q_m[$];
    int     cyc_m = 0;
    int     busy_m = -1;
    bit     ph_m = 0;
    bit     ovr_e_m = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_m.delete(); q_m.delete(); busy_m = -1; ph_m = 0; ovr_e_m = 0;
        end else begin
            cyc_m++;
            if (vld_m) begin
                if (cyc_m <= busy_m) begin
                    ovr_e_m = 1;
                end else begin
                    hist_m.push_back(longint'(in_m));
                    ph_m = !ph_m;
                    if (!ph_m) begin
                        busy_m = cyc_m + 13;
                        q_m.push_back('{cyc_m + 13, model_y(hist_m, 32, 16)});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit     ev;
        longint ex;
        ev = 0;
        ex = 0;
        if (q_m.size() > 0 && q_m[0].cyc == cyc_m) begin
            ev = 1;
            ex = q_m[0].val;
            void'(q_m.pop_front());
        end
        if (!rst_n) chk("rst_out_m", out_m, 0);
        chk("vld_m", ov_m, ev);
        chk("ovr_m", ovr_m, ovr_e_m);
        if (ev) chk("out_m", out_m, ex);
    end

    longint hist_i[$];
    exp_t   q_i[$];
    longint imp_q[$];
    int     cyc_i = 0;
    int     busy_i = -1;
    bit     ph_i = 0;
    bit     ovr_e_i = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_i.delete(); q_i.delete(); busy_i = -1; ph_i = 0; ovr_e_i = 0;
        end else begin
            cyc_i++;
            if (vld_i) begin
                if (cyc_i <= busy_i) begin
                    ovr_e_i = 1;
                end else begin
                    hist_i.push_back(longint'(in_i));
                    ph_i = !ph_i;
                    if (!ph_i) begin
                        busy_i = cyc_i + 13;
                        q_i.push_back('{cyc_i + 13, model_y(hist_i, 0, 48)});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit     ev;
        longint ex;
        ev = 0;
        ex = 0;
        if (q_i.size() > 0 && q_i[0].cyc == cyc_i) begin
            ev = 1;
            ex = q_i[0].val;
            void'(q_i.pop_front());
        end
        if (ov_i) imp_q.push_back(longint'(out_i));
        chk("vld_i", ov_i, ev);
        chk("ovr_i", ovr_i, ovr_e_i);
        if (ev) chk("out_i", out_i, ex);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_m(input longint v);
        in_m = v[30:0];
        vld_m = 1'b1;
        @(posedge clk);
        #1;
        vld_m = 1'b0;
    endtask

    task automatic send_i(input longint v);
        in_i = v[30:0];
        vld_i = 1'b1;
        @(posedge clk);
        #1;
        vld_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        int     t0;
        int     lat;
        longint sat_exp;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", out_m, 0);
        chk("reset_vld", ov_m, 0);
        chk("reset_ovr", ovr_m, 0);
        rst_n = 1'b1;
        idle(2);

        // DC gain on the main instance alongside the impulse on the wide instance
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    send_m(64'sd32768000);
                    idle(31);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    send_i((i == 0) ? 64'sd1 : 64'sd0);
                    idle(31);
                end
            end
        join
        chk("dc_gain", out_m, 1000);
        chk("imp_count", imp_q.size(), 15);
        chk("imp_m0", imp_q[0], 250);
        chk("imp_m1", imp_q[1], 520);
        chk("imp_m4", imp_q[4], 30000);
        chk("imp_m5", imp_q[5], 30000);
        chk("imp_m9", imp_q[9], 250);
        chk("imp_m10", imp_q[10], 0);

        do_reset();
        for (int i = 0; i < 50; i++) begin
            send_m(64'sd1073741823);
            idle(31);
        end
`ifdef CIC_COMP_SAT_EN
        sat_exp = 32767;
`else
        sat_exp = -32768;
`endif
        chk("saturate", out_m, sat_exp);

        do_reset();
        send_m(64'sd5000000);
        idle(31);
        send_m(64'sd7000000);
        t0 = cyc_m;
        idle(4);
        chk("ovr_before", ovr_m, 0);
        send_m(64'sd9000000);
        chk("ovr_set", ovr_m, 1);
        lat = -1;
        for (int k = 0; k < 30 && lat < 0; k++) begin
            @(negedge clk);
            if (ov_m) lat = cyc_m - t0;
        end
        chk("latency", lat, 13);
        idle(20);
        send_m(64'sd1000000);
        idle(31);
        send_m(64'sd2000000);
        idle(31);
        chk("ovr_sticky", ovr_m, 1);

        do_reset();
        send_m(64'sd3000000);
        idle(31);
        send_m(64'sd3000000);
        idle(13);
        send_m(64'sd6000000);
        send_m(64'sd6000000);
        chk("b2b_no_ovr", ovr_m, 0);
        idle(12);
        send_m(64'sd8000000);
        chk("out_cycle_ovr", ovr_m, 1);
        idle(20);

        do_reset();
        for (int i = 0; i < 26; i++) begin
            send_m(64'sd32768000);
            if (i < 25) idle(15);
        end
        idle(5);
        rst_n = 1'b0;
        idle(1);
        chk("midrst_out", out_m, 0);
        chk("midrst_vld", ov_m, 0);
        chk("midrst_ovr", ovr_m, 0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send_m(64'sd0);
            idle(15);
        end
        chk("post_rst_out", out_m, 0);

        do_reset();
        for (int i = 0; i < 200; i++) begin
            send_m(longint'(i) * 32768);
            idle(13);
        end
        idle(20);
        chk("ramp_last", out_m, 189);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
